shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data register width in bits (supported value: 8).
REQ-002 SHALL have port clock, input, 1, meaning the single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, meaning a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1, meaning a command is accepted this cycle if cmd_valid is high.
REQ-006 SHALL have port cmd_op, input, 2, meaning operation: 00 load only, 01 rotate left, 10 rotate right, 11 arithmetic shift right.
REQ-007 SHALL have port cmd_amount, input, 3, meaning number of single-bit shift steps (0-7).
REQ-008 SHALL have port cmd_data, input, WIDTH, meaning parallel load value.
REQ-009 SHALL have port q, output, WIDTH, meaning live register contents.
REQ-010 SHALL have port busy, output, 1, meaning a command is in progress.
REQ-011 SHALL have port done, output, 1, meaning a single-cycle pulse that marks command completion.
REQ-012 SHALL have port err, output, 1, meaning the completing command was unsupported; valid only with done.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL drive cmd_ready = (state==IDLE) and not reset, so cmd_valid outside IDLE is ignored with no side effect.
REQ-015 SHALL, on the accept edge (cmd_valid & cmd_ready), load q <= cmd_data and latch op and amount internally.
REQ-016 SHALL, on the accept edge, go to DONE if op==00 or amount==0, otherwise go to SHIFT with the step counter = amount.
REQ-017 SHALL perform exactly one step per SHIFT cycle and decrement the counter, moving to DONE on the edge of the last step.
REQ-018 SHALL implement rotate left as q[i] <= q[i-1] for i>0, with q[0] <= q[WIDTH-1].
REQ-019 SHALL implement rotate right as q[i] <= q[i+1] for i<WIDTH-1, with q[WIDTH-1] <= q[0].
REQ-020 SHALL implement arithmetic shift right as q[i] <= q[i+1] for i<WIDTH-1, with q[WIDTH-1] held.
REQ-021 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE, giving done amount+1 cycles after the accept edge (1 cycle for load-only or amount 0).
REQ-022 SHALL assert busy in SHIFT and DONE, and deassert it in IDLE.
REQ-023 SHALL hold q stable in DONE and IDLE until the next accept edge.
REQ-024 SHALL keep the step counter 3 bits wide, with no wrap: an amount of 7 gives 7 steps.

Reset
REQ-025 SHALL, on any clock edge with reset high, set state=IDLE, q=0, the counter and latched op to 0, and done=0, busy=0, err=0, including mid-SHIFT.
REQ-026 SHALL NOT emit done for a command aborted by reset.
REQ-027 SHALL drive cmd_ready low while reset is high and high in the first cycle after reset is released.

Configuration
REQ-028 SHALL, with SHIFT_SEQUENCER_ASR_EN defined, execute op 11 as arithmetic shift right and never assert err.
REQ-029 SHALL, without SHIFT_SEQUENCER_ASR_EN, accept op 11, load cmd_data, perform no shift, go directly to DONE, and assert err together with done.

Verification
REQ-030 SHALL cover reset: reset high for 2 cycles, then low -> q=0x00, busy=0, done=0, cmd_ready=1.
REQ-031 SHALL cover rotate left: op=01, amount=3, data=0x81 -> q sequence 0x81, 0x03, 0x06, 0x0C, with done=1 four cycles after accept and err=0.
REQ-032 SHALL cover rotate right with the zero-amount boundary: op=10, amount=1, data=0x01 -> q=0x80, done two cycles after accept; then op=10, amount=0, data=0x5A -> q=0x5A, done one cycle after accept.
REQ-033 SHALL cover arithmetic shift right: op=11, amount=2, data=0x90 -> with the macro, q=0xE4 and err=0; without it, q=0x90 and err=1 with done one cycle after accept.
REQ-034 SHALL cover busy-time commands: cmd_valid held high with a new command while busy -> not accepted; q is unaffected; accepted the cycle after DONE.
REQ-035 SHALL cover reset mid-operation: reset asserted during the second SHIFT cycle of a 7-step rotate -> next edge gives q=0x00 and IDLE, with no done pulse.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: loads a register, then applies 0-7 single-bit steps.
// Define SHIFT_SEQUENCER_ASR_EN to execute op 11 as an arithmetic shift right.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_amount,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned CNT_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_ROL  = 2'b01;
    localparam logic [OP_W-1:0] OP_ROR  = 2'b10;
    localparam logic [OP_W-1:0] OP_ASR  = 2'b11;

`ifdef SHIFT_SEQUENCER_ASR_EN
    localparam logic ASR_EN = 1'b1;
`else
    localparam logic ASR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   step_val;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               busy_d, done_d, err_d;
    logic               accept;
    logic               unsupported;

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign accept      = cmd_valid && cmd_ready;
    assign unsupported = (cmd_op == OP_ASR) && !ASR_EN;

    // One single-bit step of the latched operation
    always_comb begin
        step_val = q;
        case (op_q)
            OP_ROL:  step_val = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  step_val = {q[0], q[WIDTH-1:1]};
            OP_ASR:  step_val = {q[WIDTH-1], q[WIDTH-1:1]};
            default: step_val = q;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        q_d     = q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    q_d   = cmd_data;
                    op_d  = cmd_op;
                    cnt_d = cmd_amount;
                    if ((cmd_op == OP_LOAD) || (cmd_amount == CNT_W'(0)) || unsupported) begin
                        state_d = DONE;
                        err_d   = unsupported;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                q_d   = step_val;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            q       <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expectations follow SHIFT_SEQUENCER_ASR_EN.
module tb_shift_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_amount;
    logic [7:0] cmd_data;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       err;

    int tests_run = 0;
    int fails     = 0;

    shift_sequencer #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_amount (cmd_amount),
        .cmd_data   (cmd_data),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_amount = amt;
        cmd_data   = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_low got=%b exp=0", cmd_ready); end
        reset = 1'b0;
        #1;
        tests_run++;
        if (q !== 8'h00) begin fails++; $display("FAIL rst_q got=%h exp=00", q); end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL rst_flags busy=%b done=%b err=%b exp=000", busy, done, err);
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_high got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h81; exp_q[1] = 8'h03; exp_q[2] = 8'h06; exp_q[3] = 8'h0C;
        present(2'b01, 3'd3, 8'h81);
        for (int i = 0; i < 4; i++) begin
            tick();
            cmd_valid = 1'b0;
            tests_run++;
            if (q !== exp_q[i] || busy !== 1'b1 || done !== (i == 3)) begin
                fails++;
                $display("FAIL rol_cycle%0d q=%h busy=%b done=%b exp q=%h busy=1 done=%b", i + 1, q, busy, done, exp_q[i], (i == 3));
            end
        end
        tests_run++;
        if (err !== 1'b0) begin fails++; $display("FAIL rol_err got=%b exp=0", err); end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h0C || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL rol_idle done=%b busy=%b q=%h ready=%b exp 0 0 0c 1", done, busy, q, cmd_ready);
        end
    endtask

    task automatic test_rotate_max();
        int cycles;
        cycles = 0;
        present(2'b01, 3'd7, 8'h81);
        tick();
        cmd_valid = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles !== 8) begin fails++; $display("FAIL rol7_latency got=%0d exp=8", cycles); end
        tests_run++;
        if (q !== 8'hC0) begin fails++; $display("FAIL rol7_q got=%h exp=c0", q); end
        tick();
    endtask

    task automatic test_rotate_right();
        present(2'b10, 3'd1, 8'h01);
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (q !== 8'h01 || done !== 1'b0) begin fails++; $display("FAIL ror1_c1 q=%h done=%b exp 01 0", q, done); end
        tick();
        tests_run++;
        if (q !== 8'h80 || done !== 1'b1) begin fails++; $display("FAIL ror1_c2 q=%h done=%b exp 80 1", q, done); end
        tick();
        present(2'b10, 3'd0, 8'h5A);
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (q !== 8'h5A || done !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL ror0 q=%h done=%b err=%b exp 5a 1 0", q, done, err);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || q !== 8'h5A) begin fails++; $display("FAIL ror0_after done=%b q=%h exp 0 5a", done, q); end
    endtask

    task automatic test_asr();
        present(2'b11, 3'd2, 8'h90);
        tick();
        cmd_valid = 1'b0;
`ifdef SHIFT_SEQUENCER_ASR_EN
        tests_run++;
        if (q !== 8'h90 || done !== 1'b0) begin fails++; $display("FAIL asr_c1 q=%h done=%b exp 90 0", q, done); end
        tick();
        tests_run++;
        if (q !== 8'hC8) begin fails++; $display("FAIL asr_c2 q=%h exp c8", q); end
        tick();
        tests_run++;
        if (q !== 8'hE4 || done !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL asr_c3 q=%h done=%b err=%b exp e4 1 0", q, done, err);
        end
`else
        tests_run++;
        if (q !== 8'h90 || done !== 1'b1 || err !== 1'b1) begin
            fails++; $display("FAIL asr_unsup q=%h done=%b err=%b exp 90 1 1", q, done, err);
        end
`endif
        tick();
        tests_run++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL asr_after done=%b err=%b busy=%b exp 0 0 0", done, err, busy);
        end
    endtask

    task automatic test_busy_cmd();
        present(2'b01, 3'd2, 8'h11);
        tick();
        present(2'b00, 3'd0, 8'hFF);
        tests_run++;
        if (cmd_ready !== 1'b0 || q !== 8'h11) begin
            fails++; $display("FAIL busy_c1 ready=%b q=%h exp 0 11", cmd_ready, q);
        end
        tick();
        tests_run++;
        if (q !== 8'h22) begin fails++; $display("FAIL busy_c2 q=%h exp 22", q); end
        tick();
        tests_run++;
        if (q !== 8'h44 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL busy_done q=%h done=%b ready=%b exp 44 1 0", q, done, cmd_ready);
        end
        tick();
        tests_run++;
        if (q !== 8'h44 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL busy_idle q=%h done=%b ready=%b exp 44 0 1", q, done, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (q !== 8'hFF || done !== 1'b1) begin fails++; $display("FAIL busy_accept q=%h done=%b exp ff 1", q, done); end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        present(2'b01, 3'd7, 8'h81);
        tick();
        cmd_valid = 1'b0;
        tick();
        tests_run++;
        if (q !== 8'h03) begin fails++; $display("FAIL mid_step1 q=%h exp 03", q); end
        reset = 1'b1;
        tick();
        tests_run++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL mid_reset q=%h busy=%b done=%b ready=%b exp 00 0 0 0", q, busy, done, cmd_ready);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b exp 1", cmd_ready); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin fails++; $display("FAIL mid_no_done got=%0d exp 0", done_seen); end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_amount = 3'd0;
        cmd_data   = 8'h00;
        #1;
        test_reset();
        test_rotate_left();
        test_rotate_max();
        test_rotate_right();
        test_asr();
        test_busy_cmd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
